// File: rtl/pipe_reg_hs_if.sv
// Handshake bundle for pipe_reg_hs: upstream valid/ready/data, downstream valid/ready/data,
// flush and occupancy count. The master side drives the pipe; the slave side is the pipe.
interface pipe_reg_hs_if #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register: DEPTH valid/ready stages of N bits, with back-pressure that
// fills bubbles, a synchronous flush and a registered occupancy count.
module pipe_reg_hs #(
    parameter int           N     = 32,
    parameter int           DEPTH = 2,
    parameter logic [N-1:0] INIT  = '0
) (
    input logic          clk,
    input logic          rst_n,
    pipe_reg_hs_if.slave bus
);
    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [N-1:0]     d_q [DEPTH];
    logic [N-1:0]     d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] r;
    logic             rdy;
    logic             in_rdy, out_vld, in_xfer, out_xfer;

    // NOTE: combinational logic uses blocking '=' so the ripple temporary is read in program
    // order; only the always_ff below uses '<=' for state.
    always_comb begin
        rdy        = !v_q[DEPTH-1] | bus.out_ready;
        r[DEPTH-1] = rdy;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            rdy  = !v_q[k] | rdy;
            r[k] = rdy;
        end
    end

    assign in_rdy   = r[0] & !bus.flush;
    assign out_vld  = v_q[DEPTH-1] & !bus.flush;
    assign in_xfer  = bus.in_valid & in_rdy;
    assign out_xfer = out_vld & bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = d_q[DEPTH-1];
    assign bus.count     = count_q;

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        v_d     = v_q;
        d_d     = d_q;
        count_d = count_q;
        if (bus.flush) begin
            v_d     = '0;
            count_d = '0;
            for (int k = 0; k < DEPTH; k++) d_d[k] = INIT;
        end else begin
            if (r[0]) begin
                v_d[0] = bus.in_valid;
                if (bus.in_valid) d_d[0] = bus.in_data;
            end
            // Empty slots never overwrite data, so a stage keeps stale data while empty.
            for (int k = 1; k < DEPTH; k++) begin
                if (r[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) d_d[k] = d_q[k-1];
                end
            end
            if (in_xfer && !out_xfer) begin
                count_d = count_q + ONE;
            end else if (out_xfer && !in_xfer) begin
                count_d = count_q - ONE;
            end
        end
    end

    // NOTE: the data registers are reset as well, because out_data must read INIT straight
    // out of reset; this is a small register array, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) d_q[k] <= INIT;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: five depths share one stimulus; directed vectors target one depth
// each, then a random phase compares every depth against its own reference FIFO.
module tb_pipe_reg_hs;
    localparam logic [31:0] INIT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        rand_on;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 8;
        logic        irdy, ov;
        logic [31:0] od;
        int          cnt;
        logic [31:0] q [$];

        pipe_reg_hs_if #(.N(32), .DEPTH(D)) bus ();
        assign bus.flush     = flush;
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign irdy = bus.in_ready;
        assign ov   = bus.out_valid;
        assign od   = bus.out_data;
        assign cnt  = int'(bus.count);

        pipe_reg_hs #(.N(32), .DEPTH(D), .INIT(INIT)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        // Reference FIFO: inputs change at negedge, decisions are taken just before posedge.
        always @(negedge clk) begin
            if (rand_on) begin
                #2;
                check($sformatf("d%0d_count", D), cnt, q.size());
                check($sformatf("d%0d_in_ready", D), irdy,
                      32'(!flush && (q.size() < D || out_ready)));
                if (flush) begin
                    check($sformatf("d%0d_flush_ov", D), ov, 0);
                    q.delete();
                end else begin
                    if (ov) begin
                        check($sformatf("d%0d_data", D), od,
                              (q.size() != 0) ? q[0] : 32'hxxxx_xxxx);
                        if (out_ready && q.size() != 0) void'(q.pop_front());
                    end
                    if (in_valid && irdy) q.push_back(in_data);
                end
            end
        end
    end

    int s_cnt [6] = '{1, 2, 2, 2, 1, 0};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rand_on = 1'b0;
        #12;
        check("rst_in_ready", g_dut[1].irdy, 1);
        check("rst_out_valid", g_dut[1].ov, 0);
        check("rst_out_data", g_dut[1].od, INIT);
        check("rst_count", g_dut[1].cnt, 0);
        step();
        rst_n = 1'b1;

        // Streaming through DEPTH=2 with no back-pressure.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_data  = 32'(i + 1);
            step();
            check($sformatf("stream_ov_%0d", i), g_dut[1].ov, 32'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) check($sformatf("stream_od_%0d", i), g_dut[1].od, 32'(i));
            check($sformatf("stream_cnt_%0d", i), g_dut[1].cnt, s_cnt[i]);
        end

        // Stall to full, then release.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        #1 check("stall_rdy_empty", g_dut[1].irdy, 1);
        step(); in_data = 32'hB;
        step(); in_data = 32'hC;
        #1;
        check("stall_cnt_full", g_dut[1].cnt, 2);
        check("stall_rdy_full", g_dut[1].irdy, 0);
        step();
        check("stall_hold_cnt", g_dut[1].cnt, 2);
        check("stall_hold_od", g_dut[1].od, 32'hA);
        check("stall_hold_rdy", g_dut[1].irdy, 0);
        out_ready = 1'b1;
        #1;
        check("release_rdy", g_dut[1].irdy, 1);
        check("release_od_a", g_dut[1].od, 32'hA);
        step(); in_valid = 1'b0;
        check("release_od_b", g_dut[1].od, 32'hB);
        check("release_cnt_b", g_dut[1].cnt, 2);
        step();
        check("release_od_c", g_dut[1].od, 32'hC);
        check("release_cnt_c", g_dut[1].cnt, 1);
        step();
        check("release_empty_ov", g_dut[1].ov, 0);
        check("release_empty_cnt", g_dut[1].cnt, 0);

        // Flush on a full DEPTH=3 pipe.
        flush = 1'b1; step(); flush = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'(7 + i);
            step();
        end
        check("flush_pre_cnt", g_dut[2].cnt, 3);
        flush = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        #1;
        check("flush_in_ready", g_dut[2].irdy, 0);
        check("flush_out_valid", g_dut[2].ov, 0);
        step(); flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_cnt", g_dut[2].cnt, 0);
        check("flush_od", g_dut[2].od, INIT);
        check("flush_ov", g_dut[2].ov, 0);
        step();
        check("flush_no_xfer_cnt", g_dut[2].cnt, 0);
        check("flush_no_xfer_ov", g_dut[2].ov, 0);

        // Bubble collapse in DEPTH=4.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
        step(); in_valid = 1'b0;
        step(); in_valid = 1'b1; in_data = 32'd6;
        step(); in_valid = 1'b0;
        check("bubble_cnt", g_dut[3].cnt, 2);
        repeat (3) step();
        check("bubble_hold_cnt", g_dut[3].cnt, 2);
        out_ready = 1'b1;
        #1;
        check("bubble_ov_5", g_dut[3].ov, 1);
        check("bubble_od_5", g_dut[3].od, 32'd5);
        step();
        check("bubble_ov_6", g_dut[3].ov, 1);
        check("bubble_od_6", g_dut[3].od, 32'd6);
        check("bubble_cnt_6", g_dut[3].cnt, 1);
        step();
        check("bubble_empty_ov", g_dut[3].ov, 0);
        check("bubble_empty_cnt", g_dut[3].cnt, 0);

        // Asynchronous reset mid-cycle while DEPTH=2 holds two items.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step(); in_data = 32'h22;
        step(); in_valid = 1'b0;
        check("midrst_pre_cnt", g_dut[1].cnt, 2);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", g_dut[1].irdy, 1);
        check("midrst_out_valid", g_dut[1].ov, 0);
        check("midrst_count", g_dut[1].cnt, 0);
        check("midrst_out_data", g_dut[1].od, INIT);
        step(); rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        step();
        check("postrst_ov", g_dut[1].ov, 1);
        check("postrst_od", g_dut[1].od, 32'h33);
        flush = 1'b1; step(); flush = 1'b0;

        // Random traffic with rare flush against the per-depth reference FIFOs.
        rand_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) == 0);
            in_data   = $urandom;
        end
        step();
        rand_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
